// File: rtl/dhcp_vlg_core.sv
// DHCP client DORA controller: drives DISCOVER/REQUEST through the TX builder,
// accepts OFFER/ACK/NAK from the RX parser, handles timeouts and retries.
module dhcp_vlg_core #(
  parameter int          TIMEOUT_TICKS = 1250000,
  parameter int          RETRIES       = 3,
  parameter logic [31:0] XID_SEED      = 32'h5A3C_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctl_start,
  input  logic [31:0] ctl_pref_ip,
  output logic        ctl_ready,
  output logic        ctl_success,
  output logic        ctl_fail,
  output logic        ctl_error,
  output logic [31:0] ctl_assig_ip,
  output logic        ctl_router_val,
  output logic [31:0] ctl_router,
  output logic        ctl_subnet_val,
  output logic [31:0] ctl_subnet,
  input  logic        rx_val,
  input  logic        rx_err,
  input  logic [7:0]  rx_op,
  input  logic [31:0] rx_xid,
  input  logic [31:0] rx_yiaddr,
  input  logic [7:0]  rx_msg_type,
  input  logic        rx_srv_id_pres,
  input  logic [31:0] rx_srv_id,
  input  logic        rx_router_pres,
  input  logic [31:0] rx_router,
  input  logic        rx_subnet_pres,
  input  logic [31:0] rx_subnet,
  output logic        tx_val,
  input  logic        tx_done,
  output logic [7:0]  tx_msg_type,
  output logic [31:0] tx_xid,
  output logic [31:0] tx_req_ip,
  output logic [31:0] tx_srv_id
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DISC_TX    = 3'd1;
  localparam logic [2:0] OFFER_WAIT = 3'd2;
  localparam logic [2:0] REQ_TX     = 3'd3;
  localparam logic [2:0] ACK_WAIT   = 3'd4;
  localparam logic [2:0] BOUND      = 3'd5;
  localparam logic [2:0] FAIL       = 3'd6;

  localparam logic [31:0] TMAX = 32'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]  RMAX = 4'(RETRIES);

  logic [2:0]  state_q, state_d;
  logic [31:0] xid_q, xid_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] req_ip_q, req_ip_d;
  logic [31:0] srv_q, srv_d;
  logic [31:0] assig_q, assig_d;
  logic [31:0] router_q, router_d;
  logic [31:0] subnet_q, subnet_d;
  logic        rval_q, rval_d;
  logic        sval_q, sval_d;
  logic        err_q, err_d;

  logic        wait_st, accept, timeout, do_retry;
  logic [3:0]  retry_inc;

  assign wait_st   = (state_q == OFFER_WAIT) || (state_q == ACK_WAIT);
  assign accept    = rx_val && !rx_err && (rx_op == 8'd2) && (rx_xid == xid_q);
  assign timeout   = wait_st && (timer_q == TMAX);
  assign retry_inc = retry_q + 4'd1;

  // Next-state and datapath capture for the DORA sequence
  always_comb begin
    state_d  = state_q;
    xid_d    = xid_q;
    retry_d  = retry_q;
    timer_d  = wait_st ? timer_q + 32'd1 : '0;
    req_ip_d = req_ip_q;
    srv_d    = srv_q;
    assig_d  = assig_q;
    router_d = router_q;
    subnet_d = subnet_q;
    rval_d   = rval_q;
    sval_d   = sval_q;
    err_d    = 1'b0;
    do_retry = 1'b0;
    if (wait_st && rx_val && rx_err) err_d = 1'b1;
    case (state_q)
      IDLE, BOUND, FAIL: begin
        if (ctl_start) begin
          state_d  = DISC_TX;
          retry_d  = '0;
          req_ip_d = ctl_pref_ip;
          rval_d   = 1'b0;
          sval_d   = 1'b0;
        end
      end
      DISC_TX: begin
        if (tx_done) begin
          state_d = OFFER_WAIT;
          timer_d = '0;
        end
      end
      OFFER_WAIT: begin
        if (accept && rx_msg_type == 8'd2 && rx_srv_id_pres) begin
          state_d  = REQ_TX;
          req_ip_d = rx_yiaddr;
          srv_d    = rx_srv_id;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      REQ_TX: begin
        if (tx_done) begin
          state_d = ACK_WAIT;
          timer_d = '0;
        end
      end
      ACK_WAIT: begin
        if (accept && rx_msg_type == 8'd5) begin
          state_d  = BOUND;
          assig_d  = rx_yiaddr;
          router_d = rx_router;
          rval_d   = rx_router_pres;
          subnet_d = rx_subnet;
          sval_d   = rx_subnet_pres;
        end else if (accept && rx_msg_type == 8'd6) begin
          err_d    = 1'b1;
          do_retry = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_retry) begin
      retry_d = retry_inc;
      if (retry_inc == RMAX) begin
        state_d = FAIL;
      end else begin
        state_d = DISC_TX;
        xid_d   = xid_q + 32'd1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xid_q    <= XID_SEED;
      retry_q  <= '0;
      timer_q  <= '0;
      req_ip_q <= '0;
      srv_q    <= '0;
      assig_q  <= '0;
      router_q <= '0;
      subnet_q <= '0;
      rval_q   <= 1'b0;
      sval_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      xid_q    <= xid_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      req_ip_q <= req_ip_d;
      srv_q    <= srv_d;
      assig_q  <= assig_d;
      router_q <= router_d;
      subnet_q <= subnet_d;
      rval_q   <= rval_d;
      sval_q   <= sval_d;
      err_q    <= err_d;
    end
  end

  assign ctl_ready      = (state_q == IDLE) || (state_q == BOUND) ||
                          (state_q == FAIL);
  assign ctl_success    = (state_q == BOUND);
  assign ctl_fail       = (state_q == FAIL);
  assign ctl_error      = err_q;
  assign ctl_assig_ip   = assig_q;
  assign ctl_router_val = rval_q;
  assign ctl_router     = router_q;
  assign ctl_subnet_val = sval_q;
  assign ctl_subnet     = subnet_q;
  assign tx_val         = (state_q == DISC_TX) || (state_q == REQ_TX);
  assign tx_msg_type    = (state_q == REQ_TX) ? 8'd3 :
                          (state_q == DISC_TX) ? 8'd1 : 8'd0;
  assign tx_xid         = xid_q;
  assign tx_req_ip      = req_ip_q;
  assign tx_srv_id      = srv_q;

endmodule
